// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and data memory (slave).
interface mem_stage_if;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic [31:0] dmem_addr;
   logic        dmem_wen;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wmask;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rsp_rdata;

   modport master (
      output dmem_req_valid, dmem_addr, dmem_wen, dmem_wdata, dmem_wmask,
      input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
   );

   modport slave (
      input  dmem_req_valid, dmem_addr, dmem_wen, dmem_wdata, dmem_wmask,
      output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX->MEM segment register plus a load/store unit that runs one
// data-memory transaction per load/store and hands results to WB over valid/ready.
module mem_stage (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        ex_valid,
   output logic        mem_ready,
   input  logic        wb_ready,
   output logic        mem_valid,

   input  logic [31:0] alu_res_ex,
   input  logic [31:0] store_data_ex,
   input  logic        mem_ren_ex,
   input  logic        mem_wen_ex,
   input  logic [2:0]  mem_op_ex,
   input  logic [31:0] pc_ex,
   input  logic [31:0] inst_ex,
   input  logic [31:0] csr_rdata_ex,
   input  logic [2:0]  sel_rf_wdata_ex,
   input  logic        ecall_en_ex,
   input  logic        mret_en_ex,
   input  logic        rf_wen_ex,
   input  logic        csr_wen_ex,
   input  logic [31:0] csr_wdata_ex,
   input  logic        ebreak_ex,

   output logic [31:0] alu_res_mem,
   output logic [31:0] load_data_mem,
   output logic [31:0] pc_mem,
   output logic [31:0] inst_mem,
   output logic [31:0] csr_rdata_mem,
   output logic [2:0]  sel_rf_wdata_mem,
   output logic        ecall_en_mem,
   output logic        mret_en_mem,
   output logic        rf_wen_mem,
   output logic        csr_wen_mem,
   output logic [31:0] csr_wdata_mem,
   output logic        ebreak_mem,

   mem_stage_if.master dmem
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned SELW  = 3;
   localparam int unsigned OPW   = 3;
   localparam int unsigned MASKW = XLEN / 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] alu_res;
      logic [XLEN-1:0] csr_rdata;
      logic [XLEN-1:0] csr_wdata;
      logic [SELW-1:0] sel_rf_wdata;
      logic            ecall_en;
      logic            mret_en;
      logic            rf_wen;
      logic            csr_wen;
      logic            ebreak;
      logic            mem_ren;
      logic [OPW-1:0]  mem_op;
   } pay_t;

   state_t           state_q, state_d;
   pay_t             pay_q, pay_d;
   logic [XLEN-1:0]  load_data_q, load_data_d;
   logic             req_valid_q, req_valid_d;
   logic [XLEN-1:0]  addr_q, addr_d;
   logic             dwen_q, dwen_d;
   logic [XLEN-1:0]  wdata_q, wdata_d;
   logic [MASKW-1:0] wmask_q, wmask_d;

   logic             valid_c;
   logic             ready_go_c;
   logic             accept_c;
   logic [MASKW-1:0] st_mask_c;
   logic [XLEN-1:0]  st_wdata_c;
   logic [7:0]       ld_byte_c;
   logic [15:0]      ld_half_c;
   logic [XLEN-1:0]  ld_ext_c;

   assign valid_c    = (state_q != S_IDLE);
   assign ready_go_c = (state_q == S_DONE);
   assign mem_ready  = !valid_c || (ready_go_c && wb_ready);
   assign mem_valid  = valid_c && ready_go_c;
   assign accept_c   = mem_ready && ex_valid;

   // Store byte lanes: data replicated across the word, strobes pick the addressed lanes.
   always_comb begin
      st_mask_c  = 4'b1111;
      st_wdata_c = store_data_ex;
      unique case (mem_op_ex[1:0])
         2'b00: begin
            st_mask_c  = 4'b0001 << alu_res_ex[1:0];
            st_wdata_c = {4{store_data_ex[7:0]}};
         end
         2'b01: begin
            st_mask_c  = 4'b0011 << {alu_res_ex[1], 1'b0};
            st_wdata_c = {2{store_data_ex[15:0]}};
         end
         default: ;
      endcase
   end

   // Load extraction; halfword ignores a[0] and word ignores a[1:0].
   always_comb begin
      ld_byte_c = dmem.dmem_rsp_rdata[7:0];
      unique case (pay_q.alu_res[1:0])
         2'b00: ld_byte_c = dmem.dmem_rsp_rdata[7:0];
         2'b01: ld_byte_c = dmem.dmem_rsp_rdata[15:8];
         2'b10: ld_byte_c = dmem.dmem_rsp_rdata[23:16];
         2'b11: ld_byte_c = dmem.dmem_rsp_rdata[31:24];
      endcase
      ld_half_c = pay_q.alu_res[1] ? dmem.dmem_rsp_rdata[31:16] : dmem.dmem_rsp_rdata[15:0];
      unique case (pay_q.mem_op)
         3'b000:  ld_ext_c = {{24{ld_byte_c[7]}}, ld_byte_c};
         3'b001:  ld_ext_c = {{16{ld_half_c[15]}}, ld_half_c};
         3'b100:  ld_ext_c = {24'd0, ld_byte_c};
         3'b101:  ld_ext_c = {16'd0, ld_half_c};
         default: ld_ext_c = dmem.dmem_rsp_rdata;
      endcase
   end

   // Next-state and payload: accept from EX only in IDLE or when DONE drains into WB.
   always_comb begin
      state_d     = state_q;
      pay_d       = pay_q;
      load_data_d = load_data_q;
      req_valid_d = req_valid_q;
      addr_d      = addr_q;
      dwen_d      = dwen_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;

      unique case (state_q)
         S_REQ: begin
            if (dmem.dmem_req_ready) begin
               state_d     = S_WAIT;
               req_valid_d = 1'b0;
            end
         end
         S_WAIT: begin
            if (dmem.dmem_rsp_valid) begin
               state_d = S_DONE;
               if (pay_q.mem_ren) load_data_d = ld_ext_c;
            end
         end
         default: ;
      endcase

      if (accept_c) begin
         pay_d.pc           = pc_ex;
         pay_d.inst         = inst_ex;
         pay_d.alu_res      = alu_res_ex;
         pay_d.csr_rdata    = csr_rdata_ex;
         pay_d.csr_wdata    = csr_wdata_ex;
         pay_d.sel_rf_wdata = sel_rf_wdata_ex;
         pay_d.ecall_en     = ecall_en_ex;
         pay_d.mret_en      = mret_en_ex;
         pay_d.rf_wen       = rf_wen_ex;
         pay_d.csr_wen      = csr_wen_ex;
         pay_d.ebreak       = ebreak_ex;
         pay_d.mem_ren      = mem_ren_ex;
         pay_d.mem_op       = mem_op_ex;
         load_data_d        = '0;
         if (mem_ren_ex || mem_wen_ex) begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            addr_d      = {alu_res_ex[31:2], 2'b00};
            dwen_d      = mem_wen_ex;
            wdata_d     = mem_wen_ex ? st_wdata_c : '0;
            wmask_d     = mem_wen_ex ? st_mask_c : '0;
         end else begin
            state_d     = S_DONE;
            req_valid_d = 1'b0;
         end
      end else if (mem_ready) begin
         state_d     = S_IDLE;
         req_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pay_q       <= '0;
         load_data_q <= '0;
         req_valid_q <= 1'b0;
         addr_q      <= '0;
         dwen_q      <= 1'b0;
         wdata_q     <= '0;
         wmask_q     <= '0;
      end else begin
         state_q     <= state_d;
         pay_q       <= pay_d;
         load_data_q <= load_data_d;
         req_valid_q <= req_valid_d;
         addr_q      <= addr_d;
         dwen_q      <= dwen_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
      end
   end

   assign alu_res_mem      = pay_q.alu_res;
   assign load_data_mem    = load_data_q;
   assign pc_mem           = pay_q.pc;
   assign inst_mem         = pay_q.inst;
   assign csr_rdata_mem    = pay_q.csr_rdata;
   assign sel_rf_wdata_mem = pay_q.sel_rf_wdata;
   assign ecall_en_mem     = pay_q.ecall_en;
   assign mret_en_mem      = pay_q.mret_en;
   assign rf_wen_mem       = pay_q.rf_wen;
   assign csr_wen_mem      = pay_q.csr_wen;
   assign csr_wdata_mem    = pay_q.csr_wdata;
   assign ebreak_mem       = pay_q.ebreak;

   assign dmem.dmem_req_valid = req_valid_q;
   assign dmem.dmem_addr      = addr_q;
   assign dmem.dmem_wen       = dwen_q;
   assign dmem.dmem_wdata     = wdata_q;
   assign dmem.dmem_wmask     = wmask_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
MEM pipeline stage: segment register plus load/store unit between EX and WB. Accepts instructions from EX over a valid/ready handshake and runs a multi-cycle data-memory transaction for loads and stores. Presents results to WB as the producer end of the mem_valid/wb_ready handshake, so ready_go is not constant here. Output field set is exactly what the WB segment register consumes.

Parameters:
none (XLEN fixed at 32)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ex_valid  input  1  EX holds a valid instruction
mem_ready  output  1  stage can accept from EX this cycle
wb_ready  input  1  WB can accept this cycle
mem_valid  output  1  result valid toward WB
alu_res_ex / alu_res_mem  in/out  32  ALU result; effective address for loads/stores
store_data_ex  input  32  rs2 value for stores
mem_ren_ex  input  1  instruction is a load
mem_wen_ex  input  1  instruction is a store
mem_op_ex  input  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
load_data_mem  output  32  extended load result
Pass-through fields (X_ex input, X_mem output, same width): pc 32, inst 32, csr_rdata 32, sel_rf_wdata 3, ecall_en 1, mret_en 1, rf_wen 1, csr_wen 1, csr_wdata 32, ebreak 1
dmem_req_valid  output  1  memory request valid
dmem_req_ready  input  1  memory accepts request
dmem_addr  output  32  {alu_res[31:2], 2'b00}
dmem_wen  output  1  1 = store
dmem_wdata  output  32  lane-replicated store data
dmem_wmask  output  4  byte strobes
dmem_rsp_valid  input  1  response valid, one pulse per request (stores included)
dmem_rsp_rdata  input  32  read word

Behaviour:
- Reset (async, rst_n=0): valid=0, state IDLE, mem_valid=0, mem_ready=1, dmem_req_valid=0, all registered payload outputs 0.
- States: IDLE (valid=0), REQ, WAIT, DONE. ready_go = (state==DONE).
- mem_ready = !valid || (ready_go && wb_ready); mem_valid = valid && ready_go.
- Accept when mem_ready && ex_valid: latch all _ex fields; next state REQ if mem_ren_ex|mem_wen_ex, else DONE; load_data_mem=0 for non-memory ops.
- mem_ready=1 && !ex_valid: valid<=0, IDLE.
- Non-memory op: accepted cycle N, mem_valid high cycle N+1.
- REQ: dmem_req_valid=1, dmem_addr/wen/wdata/wmask held stable until dmem_req_ready; on handshake -> WAIT.
- WAIT: dmem_req_valid=0; on dmem_rsp_valid -> DONE, capture extracted load data (loads only).
- DONE: outputs held stable while wb_ready=0; on wb_ready, accept next EX instruction in same cycle (back-to-back) or go IDLE.
- Best case memory op: accept N, req handshake N+1, rsp N+2, mem_valid N+3.
- Store mask/data: sb mask 4'b0001<<a[1:0], wdata {4{d[7:0]}}; sh mask 4'b0011<<{a[1],1'b0}, wdata {2{d[15:0]}}; sw mask 4'b1111, wdata d. Loads: mask 0, wen 0.
- Load extract: b/bu byte at a[1:0], h/hu half at a[1], w full word; b/h sign-extend, bu/hu zero-extend. Unlisted funct3 treated as w.
- Misalignment not trapped: h ignores a[0], w ignores a[1:0].
- dmem_rsp_valid outside WAIT ignored (including late response after reset mid-transaction).
- Reset during REQ/WAIT: transaction abandoned, dmem_req_valid drops immediately.

Test Plan:
- ALU op (alu_res_ex=0x1234, rf_wen=1), wb_ready=1 -> mem_valid one cycle after accept, alu_res_mem=0x1234, load_data_mem=0; back-to-back ops stream one per cycle.
- lb addr 0x80000003, rsp 0x80FF1234 -> dmem_addr 0x80000000, load_data_mem 0xFFFFFF80; repeat lbu -> 0x00000080; lhu addr 0x...2 -> 0x000080FF.
- sh addr 0x80000006, store_data 0x0000ABCD -> dmem_addr 0x80000004, wmask 4'b1100, wdata 0xABCDABCD, dmem_wen=1; mem_valid after rsp pulse.
- dmem_req_ready low 3 cycles -> req_valid/addr stable; mem_ready=0, no EX accept until result handed to WB.
- Result in DONE with wb_ready=0 for 4 cycles -> mem_valid held, all _mem outputs stable, mem_ready=0; wb_ready=1 with ex_valid=1 -> next accepted same cycle.
- rst_n low in WAIT, then stray dmem_rsp_valid -> mem_valid stays 0, state IDLE, no load data captured.
